// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the centisecond stopwatch (MM:SS.cc in BCD).
// Pure definitions and one combinational helper; no latency and no backpressure.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam int unsigned CS_ONES_MOD = 10;
    localparam int unsigned CS_TENS_MOD = 10;
    localparam int unsigned S_ONES_MOD  = 10;
    localparam int unsigned S_TENS_MOD  = 6;
    localparam int unsigned M_ONES_MOD  = 10;
    localparam int unsigned M_TENS_MOD  = 6;

    localparam int NUM_DIGITS = 6;

    // Index 0 is the least significant digit (cs_ones).
    localparam int unsigned DIGIT_MOD [NUM_DIGITS] = '{
        CS_ONES_MOD, CS_TENS_MOD, S_ONES_MOD, S_TENS_MOD, M_ONES_MOD, M_TENS_MOD
    };

    localparam logic [23:0] MAX_COUNT = 24'h595999;

    // Value the digit chain will hold after one counted tick.
    function automatic logic [23:0] bcd_inc(input logic [23:0] v);
        logic [23:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (c) begin
                if (v[4*i +: 4] == bcd_t'(DIGIT_MOD[i] - 1)) begin
                    r[4*i +: 4] = '0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/stopwatch_counter_bcd_digit.sv
// One BCD digit of the stopwatch count with a combinational carry out.
// Value updates one edge after inc; no backpressure.
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter int unsigned MODULUS = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output bcd_t value,
    output logic carry
);

    localparam bcd_t TOP = bcd_t'(MODULUS - 1);

    assign carry = inc && (value == TOP);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            value <= '0;
        end else if (inc) begin
            value <= (value == TOP) ? '0 : value + 4'd1;
        end
    end

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch with run/pause/lap control and a six-digit BCD count; outputs registered.
// disp follows the count register with zero extra latency (frozen in LAP); no backpressure.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter bit WRAP_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        lap,
    output logic [23:0] disp,
    output logic        running,
    output logic        lap_active,
    output logic        wrap
);

    state_t                state;
    state_t                state_next;
    logic [23:0]           count;
    logic [23:0]           count_next;
    logic [23:0]           lap_q;
    logic [23:0]           lap_next;
    logic [NUM_DIGITS:0]   chain;
    logic                  counting;
    logic                  at_max;
    logic                  sat;
    logic                  clear_act;
    logic                  wrap_evt;

    // A tick counts off the current state register, whatever transition happens this edge.
    assign counting  = tick && (state == RUN || state == LAP);
    assign at_max    = (count == MAX_COUNT);
    assign sat       = !WRAP_EN && counting && at_max;
    assign clear_act = clear && (state == PAUSE);
    assign chain[0]  = counting && !sat;
    assign wrap_evt  = chain[NUM_DIGITS] || sat;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        bcd_digit #(
            .MODULUS (DIGIT_MOD[i])
        ) u_digit (
            .clk   (clk),
            .reset (reset),
            .clr   (clear_act),
            .inc   (chain[i]),
            .value (count[4*i +: 4]),
            .carry (chain[i+1])
        );
    end

    assign count_next = clear_act ? '0 : (chain[0] ? bcd_inc(count) : count);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_stop) state_next = RUN;
            RUN:     if (start_stop) state_next = PAUSE;
                     else if (lap)   state_next = LAP;
            LAP:     if (start_stop) state_next = PAUSE;
                     else if (lap)   state_next = RUN;
            PAUSE:   if (clear)      state_next = IDLE;
                     else if (start_stop) state_next = RUN;
            default: state_next = IDLE;
        endcase
        if (sat) begin
            state_next = PAUSE;
        end
    end

    assign lap_next = (state_next == LAP && state != LAP) ? count_next : lap_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            lap_q      <= '0;
            disp       <= '0;
            running    <= 1'b0;
            lap_active <= 1'b0;
            wrap       <= 1'b0;
        end else begin
            state      <= state_next;
            lap_q      <= lap_next;
            disp       <= (state_next == LAP) ? lap_next : count_next;
            running    <= (state_next == RUN) || (state_next == LAP);
            lap_active <= (state_next == LAP);
            wrap       <= wrap_evt;
        end
    end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Scoreboarded bench: one wrapping and one saturating stopwatch driven in lockstep.
module tb_stopwatch_counter;

    logic        clk = 1'b0;
    logic        reset, tick, start_stop, clear, lap;
    logic [23:0] disp_w, disp_s;
    logic        running_w, running_s, lap_active_w, lap_active_s, wrap_w, wrap_s;

    stopwatch_counter #(.WRAP_EN(1'b1)) dut_w (
        .clk(clk), .reset(reset), .tick(tick), .start_stop(start_stop), .clear(clear),
        .lap(lap), .disp(disp_w), .running(running_w), .lap_active(lap_active_w), .wrap(wrap_w)
    );

    stopwatch_counter #(.WRAP_EN(1'b0)) dut_s (
        .clk(clk), .reset(reset), .tick(tick), .start_stop(start_stop), .clear(clear),
        .lap(lap), .disp(disp_s), .running(running_s), .lap_active(lap_active_s), .wrap(wrap_s)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] disp;
        logic        running;
        logic        lap_active;
        logic        wrap;
    } obs_t;

    typedef struct packed {
        obs_t w;
        obs_t s;
    } exp_t;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_LAP   = 3;
    localparam int MAX_CS  = 59*6000 + 59*100 + 99;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    // Reference model: elapsed time as a plain centisecond integer.
    int m_st[2];
    int m_cnt[2];
    int m_lap[2];
    bit m_wrap[2];

    function automatic logic [23:0] to_bcd(input int c);
        int mm, ss, cc;
        mm = c / 6000;
        ss = (c / 100) % 60;
        cc = c % 100;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
    endfunction

    task automatic model_step(input int k, input bit we);
        int st, ns, cnt;
        bit counted;
        st = m_st[k];
        cnt = m_cnt[k];
        m_wrap[k] = 1'b0;
        if (reset) begin
            m_st[k] = S_IDLE;
            m_cnt[k] = 0;
            m_lap[k] = 0;
            return;
        end
        counted = tick && (st == S_RUN || st == S_LAP);
        ns = st;
        case (st)
            S_IDLE: if (start_stop) ns = S_RUN;
            S_RUN:  if (start_stop) ns = S_PAUSE; else if (lap) ns = S_LAP;
            S_LAP:  if (start_stop) ns = S_PAUSE; else if (lap) ns = S_RUN;
            default: begin
                if (clear) begin
                    ns = S_IDLE;
                    cnt = 0;
                end else if (start_stop) begin
                    ns = S_RUN;
                end
            end
        endcase
        if (counted) begin
            if (cnt == MAX_CS) begin
                m_wrap[k] = 1'b1;
                if (we) cnt = 0;
                else ns = S_PAUSE;
            end else begin
                cnt = cnt + 1;
            end
        end
        if (ns == S_LAP && st != S_LAP) m_lap[k] = cnt;
        m_st[k] = ns;
        m_cnt[k] = cnt;
    endtask

    function automatic obs_t expect_obs(input int k);
        obs_t o;
        o.disp       = to_bcd(m_st[k] == S_LAP ? m_lap[k] : m_cnt[k]);
        o.running    = (m_st[k] == S_RUN) || (m_st[k] == S_LAP);
        o.lap_active = (m_st[k] == S_LAP);
        o.wrap       = m_wrap[k];
        return o;
    endfunction

    task automatic step(input bit rs, input bit t, input bit ss, input bit cl, input bit lp);
        exp_t e;
        @(negedge clk);
        reset = rs;
        tick = t;
        start_stop = ss;
        clear = cl;
        lap = lp;
        model_step(0, 1'b1);
        model_step(1, 1'b0);
        e.w = expect_obs(0);
        e.s = expect_obs(1);
        sb_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic compare(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got disp=%h run=%b lap=%b wrap=%b expected disp=%h run=%b lap=%b wrap=%b",
                     name, act.disp, act.running, act.lap_active, act.wrap,
                     exp.disp, exp.running, exp.lap_active, exp.wrap);
        end
    endtask

    // Directed check of one DUT against a hand-written constant.
    task automatic chk(input string name, input obs_t act, input obs_t exp);
        compare(name, act, exp);
    endtask

    function automatic obs_t mk(input logic [23:0] d, input bit r, input bit l, input bit w);
        obs_t o;
        o.disp = d;
        o.running = r;
        o.lap_active = l;
        o.wrap = w;
        return o;
    endfunction

    // Monitor: outputs are valid every cycle, so pop one expectation per edge.
    initial begin
        exp_t e;
        obs_t aw, as_;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                aw  = mk(disp_w, running_w, lap_active_w, wrap_w);
                as_ = mk(disp_s, running_s, lap_active_s, wrap_s);
                compare("sb_wrap_dut", aw, e.w);
                compare("sb_sat_dut", as_, e.s);
            end
        end
    end

    initial begin
        reset = 1'b1;
        tick = 1'b0;
        start_stop = 1'b0;
        clear = 1'b0;
        lap = 1'b0;

        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("reset_w", mk(disp_w, running_w, lap_active_w, wrap_w), mk(24'h0, 0, 0, 0));
        chk("reset_s", mk(disp_s, running_s, lap_active_s, wrap_s), mk(24'h0, 0, 0, 0));

        step(0, 1, 1, 0, 0);
        ticks(150);
        chk("run_150", mk(disp_w, running_w, lap_active_w, wrap_w), mk(24'h000150, 1, 0, 0));

        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        ticks(10);
        step(0, 0, 0, 0, 1);
        ticks(25);
        chk("lap_frozen", mk(disp_w, running_w, lap_active_w, wrap_w), mk(24'h000010, 1, 1, 0));
        step(0, 0, 0, 0, 1);
        chk("lap_release", mk(disp_w, running_w, lap_active_w, wrap_w), mk(24'h000035, 1, 0, 0));

        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        ticks(9);
        step(0, 1, 1, 0, 0);
        chk("tick_with_stop", mk(disp_w, running_w, lap_active_w, wrap_w), mk(24'h000010, 0, 0, 0));
        ticks(5);
        chk("paused_ticks", mk(disp_w, running_w, lap_active_w, wrap_w), mk(24'h000010, 0, 0, 0));

        step(0, 0, 1, 0, 0);
        ticks(190);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 0);
        chk("clear_beats_start", mk(disp_w, running_w, lap_active_w, wrap_w), mk(24'h0, 0, 0, 0));
        step(0, 0, 1, 0, 0);
        ticks(5);
        step(0, 0, 0, 1, 0);
        chk("clear_in_run", mk(disp_w, running_w, lap_active_w, wrap_w), mk(24'h000005, 1, 0, 0));

        step(0, 1, 0, 0, 1);
        ticks(3);
        step(1, 1, 0, 0, 1);
        chk("reset_in_lap", mk(disp_w, running_w, lap_active_w, wrap_w), mk(24'h0, 0, 0, 0));

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 11) == 0);
        end

        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        ticks(MAX_CS);
        chk("preload_w", mk(disp_w, running_w, lap_active_w, wrap_w), mk(24'h595999, 1, 0, 0));
        chk("preload_s", mk(disp_s, running_s, lap_active_s, wrap_s), mk(24'h595999, 1, 0, 0));
        ticks(1);
        chk("wrap_w", mk(disp_w, running_w, lap_active_w, wrap_w), mk(24'h0, 1, 0, 1));
        chk("sat_s", mk(disp_s, running_s, lap_active_s, wrap_s), mk(24'h595999, 0, 0, 1));
        ticks(1);
        chk("wrap_w_drop", mk(disp_w, running_w, lap_active_w, wrap_w), mk(24'h000001, 1, 0, 0));
        chk("sat_s_drop", mk(disp_s, running_s, lap_active_s, wrap_s), mk(24'h595999, 0, 0, 0));

        for (int i = 0; i < 400; i++) begin
            step(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 29) == 0, $urandom_range(0, 9) == 0);
        end

        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d pending expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
